// File: rtl/btb_assoc.sv
// btb_assoc: set-associative multi-port BTB with counter training and a post-reset/flush invalidate sweep.
// Optional BTB_BYPASS_EN forwards same-cycle commit writes to matching lookups.
module btb_assoc #(
   parameter int ADDR     = 32,
   parameter int BTB_D    = 64,
   parameter int WAY      = 2,
   parameter int FETCH    = 2,
   parameter int SIMBRCOM = 2,
   parameter int CNT      = 2
) (
   input  logic                       clk,
   input  logic                       reset_,
   input  logic                       btb_flush_,
   output logic                       btb_busy,
   input  logic [FETCH*ADDR-1:0]      btb_addr,
   output logic [FETCH-1:0]           target_valid,
   output logic [FETCH*ADDR-1:0]      target_addr,
   input  logic [SIMBRCOM-1:0]        pc_chg_com_,
   input  logic [SIMBRCOM-1:0]        chg_taken_,
   input  logic [SIMBRCOM*ADDR-1:0]   com_addr,
   input  logic [SIMBRCOM*ADDR-1:0]   com_tar_addr
);
   localparam int IDX = $clog2(BTB_D);
   localparam int TW  = ADDR - IDX - 2;
   localparam int VW  = WAY > 1 ? $clog2(WAY) : 1;
   localparam logic [CNT-1:0] CMAX  = '1;
   localparam logic [CNT-1:0] CHALF = CNT'(1) << (CNT - 1);
   typedef enum logic {SWEEP, RUN} state_t;
   state_t state, state_n;
   logic [IDX-1:0] sidx;
   logic           valid [BTB_D][WAY];
   logic [TW-1:0]  tag   [BTB_D][WAY];
   logic [ADDR-1:0] tgt  [BTB_D][WAY];
   logic [CNT-1:0] cnt   [BTB_D][WAY];
   logic [VW-1:0]  vic   [BTB_D];
   logic [IDX-1:0] cset [SIMBRCOM];
   logic [TW-1:0]  ctag [SIMBRCOM];
   logic [VW-1:0]  cway [SIMBRCOM];
   logic [CNT-1:0] ncnt [SIMBRCOM];
   logic [SIMBRCOM-1:0] chit, full, wr;
   logic [IDX-1:0] lset [FETCH];
   logic [TW-1:0]  ltag [FETCH];
   logic [FETCH-1:0] lv;
   logic [FETCH*ADDR-1:0] la;
   logic [1:0] unused_f [FETCH];
   logic [1:0] unused_c [SIMBRCOM];
   for (genvar n = 0; n < FETCH; n++) begin : g_lk
      assign lset[n]     = btb_addr[n*ADDR+2 +: IDX];
      assign ltag[n]     = btb_addr[n*ADDR+IDX+2 +: TW];
      assign unused_f[n] = btb_addr[n*ADDR +: 2];
   end
   for (genvar p = 0; p < SIMBRCOM; p++) begin : g_cm
      assign cset[p]     = com_addr[p*ADDR+2 +: IDX];
      assign ctag[p]     = com_addr[p*ADDR+IDX+2 +: TW];
      assign unused_c[p] = com_addr[p*ADDR +: 2];
   end
   assign btb_busy = state == SWEEP;
   always_comb begin
      state_n = state;
      if (state == SWEEP) state_n = sidx == IDX'(BTB_D - 1) ? RUN : SWEEP;
      if (!btb_flush_) state_n = SWEEP;
   end
   // Victim choice: lowest invalid way, else the set's round-robin pointer; a tag hit overrides.
   always_comb begin
      chit = '0;
      full = '1;
      wr   = '0;
      for (int p = 0; p < SIMBRCOM; p++) begin
         cway[p] = '0;
         for (int w = WAY - 1; w >= 0; w--)
            if (!valid[cset[p]][w]) begin
               full[p] = 1'b0;
               cway[p] = VW'(w);
            end
         if (full[p]) cway[p] = vic[cset[p]];
         for (int w = 0; w < WAY; w++)
            if (valid[cset[p]][w] && tag[cset[p]][w] == ctag[p]) begin
               chit[p] = 1'b1;
               cway[p] = VW'(w);
            end
         wr[p] = state == RUN && !pc_chg_com_[p] && (chit[p] || !chg_taken_[p]);
         for (int q = 0; q < p; q++)
            if (!pc_chg_com_[q] && cset[q] == cset[p]) wr[p] = 1'b0;
         ncnt[p] = !chit[p] ? CHALF :
                   !chg_taken_[p] ? (cnt[cset[p]][cway[p]] == CMAX ? CMAX : cnt[cset[p]][cway[p]] + CNT'(1)) :
                   (cnt[cset[p]][cway[p]] == '0 ? '0 : cnt[cset[p]][cway[p]] - CNT'(1));
      end
   end
   always_comb begin
      lv = '0;
      la = '0;
      for (int n = 0; n < FETCH; n++) begin
         for (int w = 0; w < WAY; w++)
            if (valid[lset[n]][w] && tag[lset[n]][w] == ltag[n]) begin
               lv[n]              = cnt[lset[n]][w][CNT-1];
               la[n*ADDR +: ADDR] = tgt[lset[n]][w];
            end
`ifdef BTB_BYPASS_EN
         for (int p = SIMBRCOM - 1; p >= 0; p--)
            if (wr[p] && cset[p] == lset[n] && ctag[p] == ltag[n]) begin
               lv[n]              = ncnt[p][CNT-1];
               la[n*ADDR +: ADDR] = !chg_taken_[p] ? com_tar_addr[p*ADDR +: ADDR] : tgt[cset[p]][cway[p]];
            end
`endif
         if (!lv[n] || state != RUN) begin
            lv[n]              = 1'b0;
            la[n*ADDR +: ADDR] = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_) begin
         state        <= SWEEP;
         sidx         <= '0;
         target_valid <= '0;
         target_addr  <= '0;
      end else begin
         state        <= state_n;
         sidx         <= state == SWEEP && btb_flush_ ? sidx + IDX'(1) : '0;
         target_valid <= lv;
         target_addr  <= la;
      end
   end
   // Sweep and training never collide: commits are only applied in RUN.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         for (int w = 0; w < WAY; w++) valid[sidx][w] <= 1'b0;
         vic[sidx] <= '0;
      end
      for (int p = 0; p < SIMBRCOM; p++)
         if (wr[p]) begin
            valid[cset[p]][cway[p]] <= 1'b1;
            tag[cset[p]][cway[p]]   <= ctag[p];
            cnt[cset[p]][cway[p]]   <= ncnt[p];
            if (!chg_taken_[p]) tgt[cset[p]][cway[p]] <= com_tar_addr[p*ADDR +: ADDR];
            if (!chit[p] && full[p]) vic[cset[p]] <= WAY > 1 ? vic[cset[p]] + VW'(1) : '0;
         end
   end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: randomized and directed checks of btb_assoc against a table-level reference model.
module tb_btb_assoc;
   localparam int ADDR = 32, BTB_D = 64, WAY = 2, FETCH = 2, SC = 2, CNT = 2;
   localparam int IDX = 6, TW = ADDR - IDX - 2;
   localparam int CHALF = 1 << (CNT - 1), CMAX = (1 << CNT) - 1;
   logic clk = 1'b0;
   logic reset_ = 1'b0;
   logic btb_flush_ = 1'b1;
   logic btb_busy;
   logic [FETCH*ADDR-1:0] btb_addr = '0;
   logic [FETCH-1:0] target_valid;
   logic [FETCH*ADDR-1:0] target_addr;
   logic [SC-1:0] pc_chg_com_ = '1;
   logic [SC-1:0] chg_taken_ = '1;
   logic [SC*ADDR-1:0] com_addr = '0;
   logic [SC*ADDR-1:0] com_tar_addr = '0;
   btb_assoc #(.ADDR(ADDR), .BTB_D(BTB_D), .WAY(WAY), .FETCH(FETCH), .SIMBRCOM(SC), .CNT(CNT)) dut (
      .clk(clk), .reset_(reset_), .btb_flush_(btb_flush_), .btb_busy(btb_busy),
      .btb_addr(btb_addr), .target_valid(target_valid), .target_addr(target_addr),
      .pc_chg_com_(pc_chg_com_), .chg_taken_(chg_taken_), .com_addr(com_addr), .com_tar_addr(com_tar_addr)
   );
   always #5 clk = ~clk;
   // Reference model: a table of entries per set, cleared wholesale when a sweep begins.
   bit              m_v   [BTB_D][WAY];
   logic [TW-1:0]   m_tag [BTB_D][WAY];
   logic [ADDR-1:0] m_tar [BTB_D][WAY];
   int              m_c   [BTB_D][WAY];
   int              m_rr  [BTB_D];
   bit              m_sweep;
   int              m_rem;
   logic [FETCH-1:0] exp_tv;
   logic [FETCH*ADDR-1:0] exp_ta;
   logic exp_busy;
   int total = 0, bad = 0;
   task automatic m_clear();
      for (int s = 0; s < BTB_D; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAY; w++) m_v[s][w] = 1'b0;
      end
   endtask
   task automatic m_lookup(input logic [ADDR-1:0] a, output logic v, output logic [ADDR-1:0] t);
      int s;
      s = int'(a[IDX+1:2]);
      v = 1'b0;
      t = '0;
      for (int w = 0; w < WAY; w++)
         if (m_v[s][w] && m_tag[s][w] == a[ADDR-1:IDX+2] && m_c[s][w] >= CHALF) begin
            v = 1'b1;
            t = m_tar[s][w];
         end
   endtask
   task automatic predict();
      logic v;
      logic [ADDR-1:0] t, a;
      logic [TW-1:0] tg;
      bit claimed [BTB_D];
      logic [ADDR-3:0] wa [$];
      int s, hw, w;
      bit tk;
      for (int i = 0; i < BTB_D; i++) claimed[i] = 1'b0;
      exp_tv = '0;
      exp_ta = '0;
      if (!reset_) begin
         m_sweep = 1'b1;
         m_rem = BTB_D;
         m_clear();
      end else if (m_sweep) begin
         m_rem = !btb_flush_ ? BTB_D : m_rem - 1;
         if (m_rem == 0) m_sweep = 1'b0;
      end else begin
         for (int n = 0; n < FETCH; n++) begin
            m_lookup(btb_addr[n*ADDR +: ADDR], v, t);
            exp_tv[n] = v;
            exp_ta[n*ADDR +: ADDR] = t;
         end
         for (int p = 0; p < SC; p++) begin
            if (pc_chg_com_[p]) continue;
            a = com_addr[p*ADDR +: ADDR];
            s = int'(a[IDX+1:2]);
            tg = a[ADDR-1:IDX+2];
            tk = !chg_taken_[p];
            if (claimed[s]) continue;
            claimed[s] = 1'b1;
            hw = -1;
            for (int i = 0; i < WAY; i++) if (m_v[s][i] && m_tag[s][i] == tg) hw = i;
            if (hw >= 0) begin
               if (tk) begin
                  m_c[s][hw] = m_c[s][hw] < CMAX ? m_c[s][hw] + 1 : CMAX;
                  m_tar[s][hw] = com_tar_addr[p*ADDR +: ADDR];
               end else m_c[s][hw] = m_c[s][hw] > 0 ? m_c[s][hw] - 1 : 0;
               wa.push_back(a[ADDR-1:2]);
            end else if (tk) begin
               w = -1;
               for (int i = WAY - 1; i >= 0; i--) if (!m_v[s][i]) w = i;
               if (w < 0) begin
                  w = m_rr[s];
                  m_rr[s] = (m_rr[s] + 1) % WAY;
               end
               m_v[s][w] = 1'b1;
               m_tag[s][w] = tg;
               m_tar[s][w] = com_tar_addr[p*ADDR +: ADDR];
               m_c[s][w] = CHALF;
               wa.push_back(a[ADDR-1:2]);
            end
         end
`ifdef BTB_BYPASS_EN
         for (int n = 0; n < FETCH; n++)
            foreach (wa[k])
               if (wa[k] == btb_addr[n*ADDR+2 +: ADDR-2]) begin
                  m_lookup(btb_addr[n*ADDR +: ADDR], v, t);
                  exp_tv[n] = v;
                  exp_ta[n*ADDR +: ADDR] = t;
               end
`endif
         if (!btb_flush_) begin
            m_sweep = 1'b1;
            m_rem = BTB_D;
            m_clear();
         end
      end
      exp_busy = m_sweep;
   endtask
   task automatic step();
      predict();
      @(posedge clk);
      #1;
   endtask
   task automatic commit(input int p, input logic [ADDR-1:0] a, input logic [ADDR-1:0] t, input bit tk);
      pc_chg_com_[p] = 1'b0;
      chg_taken_[p] = !tk;
      com_addr[p*ADDR +: ADDR] = a;
      com_tar_addr[p*ADDR +: ADDR] = t;
   endtask
   task automatic idle_commits();
      pc_chg_com_ = '1;
      chg_taken_ = '1;
   endtask
   task automatic lookup(input int n, input logic [ADDR-1:0] a);
      btb_addr[n*ADDR +: ADDR] = a;
   endtask
   function automatic logic [ADDR-1:0] rand_addr();
      logic [IDX-1:0] sets [4];
      logic [TW-1:0] tg;
      logic [1:0] lo;
      sets[0] = 6'd29; sets[1] = 6'd30; sets[2] = 6'd0; sets[3] = 6'd63;
      tg = ($urandom_range(0, 7) == 0) ? 24'hdeadbe : TW'($urandom_range(0, 3));
      lo = 2'($urandom_range(0, 3));
      return {tg, sets[$urandom_range(0, 3)], lo};
   endfunction
   task automatic do_reset();
      idle_commits();
      btb_flush_ = 1'b1;
      reset_ = 1'b0;
      step();
      reset_ = 1'b1;
      repeat (BTB_D) step();
   endtask
   task automatic test_reset();
      reset_ = 1'b0;
      idle_commits();
      step();
      step();
      total++; if (target_valid !== '0) begin bad++; $display("FAIL reset_tv got=%b exp=0", target_valid); end
      total++; if (target_addr !== '0) begin bad++; $display("FAIL reset_ta got=%h exp=0", target_addr); end
      total++; if (btb_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", btb_busy); end
      reset_ = 1'b1;
      for (int i = 0; i < BTB_D; i++) begin
         lookup(0, rand_addr());
         lookup(1, rand_addr());
         commit(0, rand_addr(), $urandom, 1'b1);
         step();
         total++; if (btb_busy !== (i < BTB_D - 1)) begin bad++; $display("FAIL sweep_busy i=%0d got=%b exp=%b", i, btb_busy, i < BTB_D - 1); end
         total++; if (target_valid !== '0) begin bad++; $display("FAIL sweep_tv i=%0d got=%b exp=0", i, target_valid); end
      end
      idle_commits();
   endtask
   task automatic test_alloc();
      commit(0, 32'hdeadbe74, 32'hcafecafe, 1'b1);
      step();
      idle_commits();
      lookup(0, 32'hdeadbe74);
      lookup(1, 32'hdeadbe78);
      step();
      total++; if (target_valid !== 2'b01) begin bad++; $display("FAIL alloc_tv got=%b exp=01", target_valid); end
      total++; if (target_addr[0 +: ADDR] !== 32'hcafecafe) begin bad++; $display("FAIL alloc_ta0 got=%h exp=cafecafe", target_addr[0 +: ADDR]); end
      total++; if (target_addr[ADDR +: ADDR] !== '0) begin bad++; $display("FAIL alloc_ta1 got=%h exp=0", target_addr[ADDR +: ADDR]); end
      total++; if (target_valid !== exp_tv) begin bad++; $display("FAIL alloc_model got=%b exp=%b", target_valid, exp_tv); end
   endtask
   task automatic test_counter();
      commit(0, 32'hdeadbe74, 32'h0, 1'b0);
      step();
      idle_commits();
      step();
      total++; if (target_valid[0] !== 1'b0) begin bad++; $display("FAIL cnt_down got=%b exp=0", target_valid[0]); end
      commit(0, 32'hdeadbe74, 32'hcafecafe, 1'b1);
      step();
      idle_commits();
      step();
      total++; if (target_valid[0] !== 1'b1) begin bad++; $display("FAIL cnt_up got=%b exp=1", target_valid[0]); end
      total++; if (target_addr[0 +: ADDR] !== 32'hcafecafe) begin bad++; $display("FAIL cnt_up_ta got=%h exp=cafecafe", target_addr[0 +: ADDR]); end
   endtask
   task automatic test_evict();
      do_reset();
      commit(0, 32'h74, 32'h1111, 1'b1); step();
      commit(0, 32'h174, 32'h2222, 1'b1); step();
      commit(0, 32'h274, 32'h3333, 1'b1); step();
      idle_commits();
      lookup(0, 32'h74);
      lookup(1, 32'h174);
      step();
      total++; if (target_valid !== 2'b10) begin bad++; $display("FAIL evict_tv got=%b exp=10", target_valid); end
      total++; if (target_addr[ADDR +: ADDR] !== 32'h2222) begin bad++; $display("FAIL evict_ta1 got=%h exp=2222", target_addr[ADDR +: ADDR]); end
      lookup(0, 32'h274);
      step();
      total++; if (target_valid[0] !== 1'b1 || target_addr[0 +: ADDR] !== 32'h3333) begin bad++; $display("FAIL evict_new got=%b/%h exp=1/3333", target_valid[0], target_addr[0 +: ADDR]); end
   endtask
   task automatic test_same_set();
      do_reset();
      commit(0, 32'h74, 32'h1000, 1'b1);
      commit(1, 32'h174, 32'h2000, 1'b1);
      step();
      idle_commits();
      lookup(0, 32'h74);
      lookup(1, 32'h174);
      step();
      total++; if (target_valid !== 2'b01) begin bad++; $display("FAIL same_set_tv got=%b exp=01", target_valid); end
      total++; if (target_addr[0 +: ADDR] !== 32'h1000) begin bad++; $display("FAIL same_set_ta got=%h exp=1000", target_addr[0 +: ADDR]); end
   endtask
   task automatic test_flush();
      commit(0, 32'hdeadbe74, 32'hcafecafe, 1'b1);
      step();
      idle_commits();
      btb_flush_ = 1'b0;
      step();
      btb_flush_ = 1'b1;
      total++; if (btb_busy !== 1'b1) begin bad++; $display("FAIL flush_busy0 got=%b exp=1", btb_busy); end
      lookup(0, 32'h74);
      lookup(1, 32'hdeadbe74);
      for (int i = 0; i < BTB_D; i++) begin
         commit(0, 32'h74, 32'h5555, 1'b1);
         commit(1, 32'hdeadbe78, 32'h6666, 1'b1);
         step();
         total++; if (btb_busy !== (i < BTB_D - 1)) begin bad++; $display("FAIL flush_busy i=%0d got=%b exp=%b", i, btb_busy, i < BTB_D - 1); end
         total++; if (target_valid !== '0) begin bad++; $display("FAIL flush_tv i=%0d got=%b exp=0", i, target_valid); end
      end
      idle_commits();
      for (int i = 0; i < 3; i++) begin
         lookup(0, i == 0 ? 32'h74 : i == 1 ? 32'h174 : 32'hdeadbe78);
         lookup(1, 32'hdeadbe74);
         step();
         total++; if (target_valid !== '0) begin bad++; $display("FAIL post_flush_tv i=%0d got=%b exp=0", i, target_valid); end
      end
   endtask
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int n = 0; n < FETCH; n++) lookup(n, rand_addr());
         idle_commits();
         for (int p = 0; p < SC; p++)
            if ($urandom_range(0, 1) == 1) commit(p, rand_addr(), $urandom, $urandom_range(0, 9) < 7);
         btb_flush_ = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         step();
         total++; if (target_valid !== exp_tv) begin bad++; $display("FAIL rand_tv i=%0d got=%b exp=%b", i, target_valid, exp_tv); end
         total++; if (target_addr !== exp_ta) begin bad++; $display("FAIL rand_ta i=%0d got=%h exp=%h", i, target_addr, exp_ta); end
         total++; if (btb_busy !== exp_busy) begin bad++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, btb_busy, exp_busy); end
      end
      btb_flush_ = 1'b1;
      idle_commits();
   endtask
   initial begin
      test_reset();
      test_alloc();
      test_counter();
      test_evict();
      test_same_set();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
